// File: rtl/iter_alu.sv
// iter_alu: registered single-cycle ALU extended with iterative multiply and
// divide, with valid/ready handshakes on both the request and result sides.
//   state | meaning
//   IDLE  | accepts requests; single-cycle ops complete from here
//   MUL   | one shift-add step per cycle
//   DIV   | one restoring-division step per cycle
//   DONE  | sign-correct, load alu_out, raise out_valid
module iter_alu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      aluSel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic            busy
);
  localparam int SH_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 2);

  localparam logic [4:0] OP_AND = 5'd0, OP_OR = 5'd1, OP_ADD = 5'd2, OP_SUB = 5'd3;
  localparam logic [4:0] OP_SLT = 5'd4, OP_XOR = 5'd5, OP_SLL = 5'd6, OP_SLTU = 5'd7;
  localparam logic [4:0] OP_SRL = 5'd8, OP_SRA = 5'd9, OP_RS1 = 5'd14, OP_RS2 = 5'd15;
  localparam logic [4:0] OP_MUL = 5'd10, OP_MULH = 5'd11, OP_MULHU = 5'd12;
  localparam logic [4:0] OP_DIV = 5'd16, OP_DIVU = 5'd17, OP_REM = 5'd18, OP_REMU = 5'd19;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [4:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic                busy_q, busy_d;
  logic                out_valid_q, out_valid_d;
  logic [XLEN-1:0]     alu_out_q, alu_out_d;

  logic                accept, is_mul, is_div, sgn_div, neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0]     mag_a, mag_b, done_res;
  logic [2*XLEN-1:0]   acc_neg;

  function automatic logic [XLEN-1:0] alu_single(input logic [4:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic [SH_W-1:0] sh;
    logic signed [XLEN-1:0] sa;
    sh = b[SH_W-1:0];
    sa = a;
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << sh;
      OP_SLTU: return {{(XLEN-1){1'b0}}, a < b};
      OP_SRL:  return a >> sh;
      OP_SRA:  return sa >>> sh;
      OP_RS1:  return a;
      OP_RS2:  return b;
      default: return '0;
    endcase
  endfunction

  // {hi, lo}: lo holds the unconsumed multiplier bits, hi the running sum
  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0] mcand);
    logic [XLEN:0] sum;
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + ({(XLEN+1){acc[0]}} & {1'b0, mcand});
    return {sum, acc[XLEN-1:1]};
  endfunction

  // {rem, quo}: quotient bits shift in from the right as dividend bits leave
  function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0] dvsr);
    logic [XLEN:0] part, diff;
    part = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff = part - {1'b0, dvsr};
    if (part >= {1'b0, dvsr}) return {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else return {part[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  endfunction

  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign busy      = busy_q;

  assign is_mul   = aluSel inside {OP_MUL, OP_MULH, OP_MULHU};
  assign is_div   = aluSel inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign sgn_div  = (aluSel == OP_DIV) || (aluSel == OP_REM);
  assign neg_a    = (sgn_div || aluSel == OP_MULH) && rs1_data[XLEN-1];
  assign neg_b    = (sgn_div || aluSel == OP_MULH) && rs2_data[XLEN-1];
  assign mag_a    = neg_a ? -rs1_data : rs1_data;
  assign mag_b    = neg_b ? -rs2_data : rs2_data;
  assign div_zero = (rs2_data == '0);
  assign div_ovf  = sgn_div && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
  assign acc_neg  = -acc_q;

  always_comb begin
    done_res = '0;
    case (op_q)
      OP_MUL:             done_res = acc_q[XLEN-1:0];
      OP_MULH, OP_MULHU:  done_res = neg_q ? acc_neg[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:    done_res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      OP_REM, OP_REMU:    done_res = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      default:            done_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    op_d        = op_q;
    neg_d       = neg_q;
    busy_d      = busy_q;
    alu_out_d   = alu_out_q;
    out_valid_d = out_valid_q && !out_ready;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = aluSel;
          // the first iteration step happens at the accept edge itself
          if (is_mul) begin
            acc_d   = mul_step({{XLEN{1'b0}}, mag_b}, mag_a);
            opnd_d  = mag_a;
            neg_d   = neg_a ^ neg_b;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S_MUL;
          end else if (is_div) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            neg_d  = 1'b0;
            if (div_zero) begin
              acc_d   = {rs1_data, {XLEN{1'b1}}};
              state_d = S_DONE;
            end else if (div_ovf) begin
              acc_d   = {{XLEN{1'b0}}, rs1_data};
              state_d = S_DONE;
            end else begin
              acc_d   = div_step({{XLEN{1'b0}}, mag_a}, mag_b);
              opnd_d  = mag_b;
              neg_d   = (aluSel == OP_REM) ? neg_a : (neg_a ^ neg_b);
              state_d = S_DIV;
            end
          end else begin
            alu_out_d   = alu_single(aluSel, rs1_data, rs2_data);
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL, S_DIV: begin
        acc_d = (state_q == S_MUL) ? mul_step(acc_q, opnd_q) : div_step(acc_q, opnd_q);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        alu_out_d   = done_res;
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
    end
  end
endmodule
